// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier
//  Purpose  : Sequential unsigned shift-add multiplier for the MULTU
//             instruction. Each clock edge with Signal==MULTU performs one
//             add/shift step. The 64-bit result stays in an internal product
//             register and is copied to dataOut only on an OUT code.
//  Ports    : clk      - rising-edge clock
//             reset    - asynchronous, active-low reset
//             dataA    - multiplicand, sampled on the load edge only
//             dataB    - multiplier, sampled on the load edge only
//             Signal   - ALU-control function code (MULTU / OUT / other)
//             dataOut  - registered product output
//  Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'b011001,
    parameter logic [5:0]  OUT   = 6'b111111
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [5:0]           Signal,
    output logic [2*WIDTH-1:0]   dataOut
);

    // One extra counter bit so the counter can represent WIDTH itself.
    localparam int              CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   product;
    logic [CNT_W-1:0]     cnt;

    logic                 is_multu;
    logic                 is_out;
    logic                 load_en;
    logic                 iter_en;

    assign is_multu = (Signal == MULTU);
    assign is_out   = (Signal == OUT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // Any code other than MULTU leaves BUSY (abort) or DONE.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (is_multu) begin
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!is_multu) begin
                    next_state = ST_IDLE;
                end else if (cnt == LAST_ITER) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!is_multu) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (datapath enables)
    // ------------------------------------------------------------------
    always_comb begin
        load_en = 1'b0;
        iter_en = 1'b0;
        case (state)
            ST_IDLE: load_en = is_multu;
            ST_BUSY: iter_en = is_multu;
            default: begin
                load_en = 1'b0;
                iter_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add datapath. In DONE nothing is enabled, so the product is
    // stable while MULTU stays asserted; an abort simply stops stepping and
    // leaves the partial product in place.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            cnt     <= '0;
        end else if (load_en) begin
            mcand   <= {{WIDTH{1'b0}}, dataA};
            mplier  <= dataB;
            product <= '0;
            cnt     <= '0;
        end else if (iter_en) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result publication: OUT copies the product in any state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut <= '0;
        end else if (is_out) begin
            dataOut <= product;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_multiplier
//  Purpose  : Self-checking bench for seq_multiplier. A behavioural model
//             tracks the product as a * (b mod 2^k) after k steps and the
//             published output; dataOut is compared against it every cycle,
//             with hand-computed literal expectations on directed cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] OUT   = 6'd63;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] dataA  = '0;
    logic [31:0] dataB  = '0;
    logic [5:0]  Signal = '0;
    logic [63:0] dataOut;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(
        .WIDTH (32),
        .MULTU (MULTU),
        .OUT   (OUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] m_a      = '0;
    logic [31:0] m_b      = '0;
    int          m_steps  = 0;
    bit          m_active = 1'b0;
    logic [63:0] m_prod   = '0;
    logic [63:0] m_out    = '0;

    // Product after k shift-add steps: only the low k multiplier bits count.
    function automatic logic [63:0] partial(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int k);
        logic [63:0] mask;
        mask = (64'd1 << k) - 64'd1;
        return {32'd0, a} * ({32'd0, b} & mask);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_a = '0; m_b = '0; m_steps = 0; m_active = 1'b0;
            m_prod = '0; m_out = '0;
        end else begin
            if (Signal == OUT) m_out = m_prod;
            if (Signal == MULTU) begin
                if (!m_active) begin
                    m_a = dataA; m_b = dataB; m_steps = 0;
                    m_prod = '0; m_active = 1'b1;
                end else if (m_steps < 32) begin
                    m_steps = m_steps + 1;
                    m_prod  = partial(m_a, m_b, m_steps);
                end
            end else begin
                m_active = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: dataOut=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] sig, input int n);
        repeat (n) begin
            Signal = sig;
            @(negedge clk);
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int n);
        dataA = a;
        dataB = b;
        drive(MULTU, n);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          n;
        logic [5:0]  code;

        fork
            forever begin
                @(negedge clk);
                check("model", dataOut, m_out);
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_value", dataOut, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_mul(32'd10, 32'd20, 33);
        drive(OUT, 2);
        check("mul_10x20", dataOut, 64'd200);

        run_mul(32'd5, 32'd15, 33);
        drive(OUT, 2);
        check("mul_5x15", dataOut, 64'd75);

        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        drive(OUT, 1);
        check("mul_max", dataOut, 64'hFFFF_FFFE_0000_0001);

        run_mul(32'd0, 32'h1234_5678, 33);
        drive(OUT, 1);
        check("mul_zero", dataOut, 64'd0);

        // Abort after load + 9 steps: 7 * (9 mod 2^9) = 63.
        run_mul(32'd7, 32'd9, 10);
        drive(6'd0, 1);
        drive(OUT, 1);
        check("abort_partial", dataOut, 64'd63);
        run_mul(32'd3, 32'd4, 33);
        drive(OUT, 2);
        check("restart_3x4", dataOut, 64'd12);

        // Asynchronous reset in the middle of a multiply.
        run_mul(32'd6, 32'd7, 15);
        #3 reset = 1'b0;
        #1 check("async_reset", dataOut, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_mul(32'd6, 32'd7, 33);
        drive(OUT, 2);
        check("after_reset_6x7", dataOut, 64'd42);

        // Hold in DONE while operands change; other codes leave dataOut.
        run_mul(32'd10, 32'd20, 33);
        dataA = 32'd99;
        drive(MULTU, 5);
        drive(6'd5, 3);
        check("hold_other_code", dataOut, 64'd42);
        drive(OUT, 2);
        check("hold_result", dataOut, 64'd200);

        // Randomised runs with random lengths, aborts and interleaved codes.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 3) ra = 32'hFFFF_FFFF;
            if (i % 8 == 5) rb = 32'd0;
            n = $urandom_range(1, 40);
            run_mul(ra, rb, n);
            if ($urandom_range(0, 1) == 1) begin
                code = 6'($urandom_range(0, 62));
                if (code == MULTU) code = 6'd0;
                drive(code, 1);
            end
            drive(OUT, 1);
            if (n >= 33)
                check("rand_full", dataOut, {32'd0, ra} * {32'd0, rb});
        end

        drive(6'd0, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
